// File: rtl/tft_pkg.sv
// Shared encodings for the TFT command/pixel sequencer: init ROM kinds,
// MIPI DCS command bytes and the sequencer state set.
package tft_pkg;

    typedef enum logic [1:0] {
        K_CMD   = 2'b00,
        K_DATA  = 2'b01,
        K_DELAY = 2'b10,
        K_END   = 2'b11
    } rom_kind_t;

    localparam logic [7:0] DCS_SWRESET = 8'h01;
    localparam logic [7:0] DCS_SLPOUT  = 8'h11;
    localparam logic [7:0] DCS_COLMOD  = 8'h3A;
    localparam logic [7:0] DCS_MADCTL  = 8'h36;
    localparam logic [7:0] DCS_DISPON  = 8'h29;
    localparam logic [7:0] DCS_CASET   = 8'h2A;
    localparam logic [7:0] DCS_RASET   = 8'h2B;
    localparam logic [7:0] DCS_RAMWR   = 8'h2C;

    localparam int unsigned ROM_AW = 4;

    typedef enum logic [3:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_DELAY,
        ST_IDLE,
        ST_WINDOW,
        ST_PIX_REQ,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_PIX_NEXT,
        ST_SEND_PULSE,
        ST_SEND_ACK,
        ST_SEND_WAIT
    } fw_state_t;

    function automatic logic [9:0] rom_entry(input rom_kind_t kind, input logic [7:0] val);
        return {kind, val};
    endfunction

endpackage

// File: rtl/tft_init_rom.sv
// Panel init list: commands, parameters and millisecond delays, ending in END.
module tft_init_rom
    import tft_pkg::*;
(
    input  logic [ROM_AW-1:0] addr,
    output logic [9:0]        entry
);

    always_comb begin
        entry = rom_entry(K_END, 8'h00);
        case (addr)
            4'd0:    entry = rom_entry(K_CMD,   DCS_SWRESET);
            4'd1:    entry = rom_entry(K_DELAY, 8'd150);
            4'd2:    entry = rom_entry(K_CMD,   DCS_SLPOUT);
            4'd3:    entry = rom_entry(K_DELAY, 8'd120);
            4'd4:    entry = rom_entry(K_CMD,   DCS_COLMOD);
            4'd5:    entry = rom_entry(K_DATA,  8'h55);
            4'd6:    entry = rom_entry(K_CMD,   DCS_MADCTL);
            4'd7:    entry = rom_entry(K_DATA,  8'h48);
            4'd8:    entry = rom_entry(K_CMD,   DCS_DISPON);
            4'd9:    entry = rom_entry(K_DELAY, 8'd20);
            default: entry = rom_entry(K_END,   8'h00);
        endcase
    end

endmodule

// File: rtl/tft_frame_writer.sv
// TFT sequencer: panel reset, init ROM playback, then full-screen window
// setup and RGB565 pixel streaming into the byte-level SPI serializer.
module tft_frame_writer
    import tft_pkg::*;
#(
    parameter int unsigned WIDTH         = 240,
    parameter int unsigned HEIGHT        = 320,
    parameter int unsigned CYCLES_PER_MS = 1000,
    parameter int unsigned RST_LOW_MS    = 10,
    parameter int unsigned RST_WAIT_MS   = 120
) (
    input  logic        clk,
    input  logic        global_reset_n,
    input  logic        enable,
    input  logic        spi_busy,
    output logic [7:0]  spi_data,
    output logic        spi_dc,
    output logic        spi_transmit,
    output logic        tft_rst_n,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        init_done,
    output logic        frame_done
);

    localparam int unsigned PRE_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CYCLES_PER_MS - 1);
    localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
    localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);
    localparam logic [3:0]  WIN_BYTES = 4'd11;

    fw_state_t         state, state_d, ret_state, ret_d;
    logic [ROM_AW-1:0] rom_ptr, rom_ptr_d;
    logic [9:0]        rom_q;
    rom_kind_t         rom_kind;
    logic [7:0]        ms_left, ms_left_d;
    logic [PRE_W-1:0]  pre, pre_d;
    logic [3:0]        widx, widx_d;
    logic [15:0]       pix_lat, pix_lat_d;
    logic [7:0]        data_d;
    logic              dc_d;
    logic [15:0]       pix_x_d, pix_y_d;
    logic              init_done_d, frame_done_d;
    logic              ms_tick, timer_done;
    logic [8:0]        win_byte;

    tft_init_rom u_rom (
        .addr  (rom_ptr),
        .entry (rom_q)
    );

    assign rom_kind = rom_kind_t'(rom_q[9:8]);

    assign spi_transmit = (state == ST_SEND_PULSE);
    assign tft_rst_n    = (state != ST_RST_LOW);
    assign pix_ready    = (state == ST_PIX_REQ);

    // Shared ms timer: ms_left counts down once per CYCLES_PER_MS cycles.
    assign ms_tick    = (pre == PRE_MAX);
    assign timer_done = (ms_left == 8'd0) || ((ms_left == 8'd1) && ms_tick);

    always_comb begin
        win_byte = {1'b0, DCS_RAMWR};
        case (widx)
            4'd0:    win_byte = {1'b0, DCS_CASET};
            4'd1:    win_byte = 9'h100;
            4'd2:    win_byte = 9'h100;
            4'd3:    win_byte = {1'b1, X_MAX[15:8]};
            4'd4:    win_byte = {1'b1, X_MAX[7:0]};
            4'd5:    win_byte = {1'b0, DCS_RASET};
            4'd6:    win_byte = 9'h100;
            4'd7:    win_byte = 9'h100;
            4'd8:    win_byte = {1'b1, Y_MAX[15:8]};
            4'd9:    win_byte = {1'b1, Y_MAX[7:0]};
            default: win_byte = {1'b0, DCS_RAMWR};
        endcase
    end

    always_comb begin
        state_d      = state;
        ret_d        = ret_state;
        rom_ptr_d    = rom_ptr;
        ms_left_d    = ms_left;
        pre_d        = pre;
        widx_d       = widx;
        pix_lat_d    = pix_lat;
        data_d       = spi_data;
        dc_d         = spi_dc;
        pix_x_d      = pix_x;
        pix_y_d      = pix_y;
        init_done_d  = init_done;
        frame_done_d = 1'b0;

        if (state == ST_RST_LOW || state == ST_RST_WAIT || state == ST_DELAY) begin
            pre_d = ms_tick ? '0 : pre + 1'b1;
            if (ms_tick && ms_left != 8'd0)
                ms_left_d = ms_left - 8'd1;
        end

        case (state)
            ST_RST_LOW: begin
                if (timer_done) begin
                    state_d   = ST_RST_WAIT;
                    ms_left_d = 8'(RST_WAIT_MS);
                    pre_d     = '0;
                end
            end
            ST_RST_WAIT: begin
                if (timer_done) begin
                    state_d   = ST_INIT;
                    rom_ptr_d = '0;
                end
            end
            ST_INIT: begin
                case (rom_kind)
                    K_CMD, K_DATA: begin
                        if (!spi_busy) begin
                            data_d    = rom_q[7:0];
                            dc_d      = (rom_kind == K_DATA);
                            ret_d     = ST_INIT;
                            state_d   = ST_SEND_PULSE;
                            rom_ptr_d = rom_ptr + 1'b1;
                        end
                    end
                    K_DELAY: begin
                        rom_ptr_d = rom_ptr + 1'b1;
                        if (rom_q[7:0] != 8'd0) begin
                            ms_left_d = rom_q[7:0];
                            pre_d     = '0;
                            state_d   = ST_DELAY;
                        end
                    end
                    default: begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                endcase
            end
            ST_DELAY: begin
                if (timer_done)
                    state_d = ST_INIT;
            end
            ST_IDLE: begin
                widx_d = '0;
                if (enable)
                    state_d = ST_WINDOW;
            end
            ST_WINDOW: begin
                if (widx == WIN_BYTES) begin
                    state_d = ST_PIX_REQ;
                    pix_x_d = '0;
                    pix_y_d = '0;
                end else if (!spi_busy) begin
                    data_d  = win_byte[7:0];
                    dc_d    = win_byte[8];
                    ret_d   = ST_WINDOW;
                    state_d = ST_SEND_PULSE;
                    widx_d  = widx + 1'b1;
                end
            end
            ST_PIX_REQ: begin
                if (pix_valid) begin
                    pix_lat_d = pix_data;
                    state_d   = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                if (!spi_busy) begin
                    data_d  = pix_lat[15:8];
                    dc_d    = 1'b1;
                    ret_d   = ST_PIX_LO;
                    state_d = ST_SEND_PULSE;
                end
            end
            ST_PIX_LO: begin
                if (!spi_busy) begin
                    data_d  = pix_lat[7:0];
                    dc_d    = 1'b1;
                    ret_d   = ST_PIX_NEXT;
                    state_d = ST_SEND_PULSE;
                end
            end
            ST_PIX_NEXT: begin
                state_d = ST_PIX_REQ;
                if (pix_x == X_MAX) begin
                    pix_x_d = '0;
                    if (pix_y == Y_MAX) begin
                        pix_y_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        pix_y_d = pix_y + 16'd1;
                    end
                end else begin
                    pix_x_d = pix_x + 16'd1;
                end
            end
            ST_SEND_PULSE: state_d = ST_SEND_ACK;
            // Serializer busy is registered and lags the pulse by one cycle.
            ST_SEND_ACK:   state_d = ST_SEND_WAIT;
            ST_SEND_WAIT: begin
                if (!spi_busy)
                    state_d = ret_state;
            end
            default: state_d = ST_RST_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state      <= ST_RST_LOW;
            ret_state  <= ST_INIT;
            rom_ptr    <= '0;
            ms_left    <= 8'(RST_LOW_MS);
            pre        <= '0;
            widx       <= '0;
            pix_lat    <= '0;
            spi_data   <= '0;
            spi_dc     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            ret_state  <= ret_d;
            rom_ptr    <= rom_ptr_d;
            ms_left    <= ms_left_d;
            pre        <= pre_d;
            widx       <= widx_d;
            pix_lat    <= pix_lat_d;
            spi_data   <= data_d;
            spi_dc     <= dc_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
            init_done  <= init_done_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_tft_frame_writer.sv
// Directed bench for tft_frame_writer on a 4x3 panel with a 4-cycle ms,
// a busy-flag serializer model and a stalling pixel source.
module tb_tft_frame_writer;

    logic        clk = 1'b0;
    logic        global_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_data;
    logic        spi_dc;
    logic        spi_transmit;
    logic        tft_rst_n;
    logic [15:0] pix_x, pix_y;
    logic        pix_ready;
    logic [15:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        init_done;
    logic        frame_done;

    always #5 clk = ~clk;

    tft_frame_writer #(
        .WIDTH         (4),
        .HEIGHT        (3),
        .CYCLES_PER_MS (4),
        .RST_LOW_MS    (10),
        .RST_WAIT_MS   (120)
    ) dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .enable         (enable),
        .spi_busy       (spi_busy),
        .spi_data       (spi_data),
        .spi_dc         (spi_dc),
        .spi_transmit   (spi_transmit),
        .tft_rst_n      (tft_rst_n),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .init_done      (init_done),
        .frame_done     (frame_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0]  log_q[$];
    int unsigned log_cyc[$];
    int unsigned cyc_n = 0;
    int unsigned viol_busy = 0, viol_consec = 0, fd_cnt = 0;
    logic        pend = 1'b0, prev_tx = 1'b0;
    int unsigned bcnt = 0;

    always @(posedge clk) cyc_n++;

    // Serializer: busy rises the cycle after accept and holds 8 cycles.
    always @(negedge clk) begin
        if (spi_transmit) begin
            log_q.push_back({spi_dc, spi_data});
            log_cyc.push_back(cyc_n);
            if (spi_busy) viol_busy++;
            if (prev_tx) viol_consec++;
            pend = 1'b1;
        end else if (pend) begin
            spi_busy = 1'b1;
            bcnt = 8;
            pend = 1'b0;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) spi_busy = 1'b0;
        end
        prev_tx = spi_transmit;
        if (frame_done) fd_cnt++;
        pix_valid = ($urandom_range(0, 2) != 0);
        pix_data  = pix_ready ? {pix_y[7:0], pix_x[7:0]} : 16'hdead;
    end

    logic [8:0] exp_init [7] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
    logic [8:0] exp_win [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                                 9'h02B, 9'h100, 9'h100, 9'h100, 9'h102, 9'h02C};

    task automatic wait_log(input string tag, input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        chk(tag, (log_q.size() >= n), 1);
    endtask

    // Panel reset low 10 ms = 40 cycles; then 120 ms = 480 cycles of wait,
    // plus one INIT cycle to fetch the first ROM entry before the pulse.
    task automatic reset_sequence(input string tag);
        int unsigned n = 0, m = 0;
        @(negedge clk);
        global_reset_n = 1'b1;
        while (!tft_rst_n && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rst_low_cycles"}, n, 40);
        while (!spi_transmit && m < 1000) begin
            @(posedge clk); #1;
            m++;
        end
        chk({tag, "_first_tx_gap"}, m, 481);
        chk({tag, "_first_byte"}, {spi_dc, spi_data}, 9'h001);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tft_rst_n"}, tft_rst_n, 0);
        chk({tag, "_spi_transmit"}, spi_transmit, 0);
        chk({tag, "_spi_data"}, spi_data, 0);
        chk({tag, "_spi_dc"}, spi_dc, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int unsigned k, done_cyc, base, idx;

        #23;
        chk_reset_outputs("por");
        reset_sequence("r1");

        k = 0;
        while (!init_done && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        done_cyc = cyc_n;
        chk("init_done_r1", init_done, 1);
        repeat (50) @(posedge clk);
        #2;
        chk("init_byte_count", log_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("init_byte%0d", i), log_q[i], exp_init[i]);
        chk("swreset_delay_gap", ((log_cyc[1] - log_cyc[0]) >= 600), 1);
        chk("init_done_after_dispon_delay", ((done_cyc - log_cyc[6]) >= 80), 1);

        @(negedge clk);
        enable = 1'b1;
        k = 0;
        while (fd_cnt == 0 && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("frame_done_pulses", fd_cnt, 1);
        chk("frame_byte_count", log_q.size(), 42);
        chk("pix_xy_after_frame", {pix_x, pix_y}, 0);
        for (int i = 0; i < 11; i++)
            chk($sformatf("window_byte%0d", i), log_q[7 + i], exp_win[i]);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                idx = 18 + 2 * (y * 4 + x);
                chk($sformatf("pix%0d_%0d_hi", x, y), log_q[idx], 9'h100 | y);
                chk($sformatf("pix%0d_%0d_lo", x, y), log_q[idx + 1], 9'h100 | x);
            end
        chk("pix3_2_hi", log_q[40], 9'h102);
        chk("pix3_2_lo", log_q[41], 9'h103);

        wait_log("frame2_start_seen", 43, 200);
        chk("frame2_first_byte", log_q[42], 9'h02A);

        // Second frame: hit reset between hi and lo bytes of pixel (0,0).
        wait_log("frame2_pix0_hi_seen", 54, 1000);
        chk("frame2_pix0_hi", log_q[53], 9'h100);
        #1;
        global_reset_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        chk("lo_byte_not_sent", log_q.size(), 54);

        #40;
        base = log_q.size();
        reset_sequence("r2");
        k = 0;
        while (!init_done && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("init_done_r2", init_done, 1);
        wait_log("replay_bytes_seen", base + 7, 200);
        for (int i = 0; i < 7; i++)
            chk($sformatf("replay_byte%0d", i), log_q[base + i], exp_init[i]);

        @(negedge clk);
        enable = 1'b0;
        repeat (600) @(posedge clk);
        #2;
        chk("tx_while_busy", viol_busy, 0);
        chk("tx_consecutive", viol_consec, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
